score_count_sequencer: RTL and testbench
========================================

Name: score_count_sequencer

Overview:
- Turns brick-hit award events into COUNT pulses for the BCD score counter chains, one pulse per point.
- Keeps a separate pending-points accumulator for each player.
- Arbitrates the single pulse generator between the two players, round-robin.
- Sits between the brick-hit/point-value logic and the player 1 / player 2 score counters. It drives their COUNT_1 and COUNT_2 clocks.

Parameters:
- PEND_W, 5, width of each pending-points accumulator; saturates at 2^PEND_W-1.
- PULSE_HIGH, 2, CLK_DRV cycles COUNT is held high per point (1..15).
- PULSE_LOW, 2, CLK_DRV cycles COUNT is held low after each pulse (1..15).

Ports:
- CLK_DRV  in  1  system clock; the only clock.
- RESET_N  in  1  asynchronous active-low reset.
- START_GAME_N  in  1  synchronous active-low game clear; flushes pending points and aborts any pulse.
- HIT  in  1  single-cycle award strobe.
- HIT_PLAYER2  in  1  sampled with HIT; 0 credits player 1, 1 credits player 2.
- HIT_POINTS  in  3  points awarded with HIT (0..7); 0 is ignored.
- COUNT_1  out  1  registered count clock to the player 1 score chain.
- COUNT_2  out  1  registered count clock to the player 2 score chain.
- BUSY  out  1  high while a pulse is in progress or either accumulator is nonzero.
- PENDING_1  out  PEND_W  player 1 points not yet pulsed.
- PENDING_2  out  PEND_W  player 2 points not yet pulsed.
- OVERFLOW  out  1  sticky flag: an accumulator saturated.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - COUNT_1, COUNT_2, BUSY, OVERFLOW = 0.
  - PENDING_1, PENDING_2 = 0.
  - FSM = IDLE; round-robin pointer = player 1; timer = 0.
- START_GAME_N=0 at a rising edge has the same effect as reset, but synchronously. It overrides HIT in the same cycle.
- Accumulate, per player p:
  - next = pending + (HIT && player==p ? HIT_POINTS : 0) - (issue_p ? 1 : 0).
  - Computed at PEND_W+1 bits. If the result exceeds 2^PEND_W-1, the accumulator saturates and OVERFLOW sets.
  - Increment and decrement in the same cycle are both applied.
- FSM states: IDLE, HIGH, LOW.
- IDLE:
  - If both accumulators are nonzero, select the player the pointer names.
  - Otherwise select whichever accumulator is nonzero.
  - On selection: assert issue for that player (decrement), latch the player, set the timer to PULSE_HIGH-1, go to HIGH, and toggle the pointer to the other player.
  - If neither accumulator is nonzero, stay in IDLE.
- HIGH:
  - The selected player's COUNT is 1; the other COUNT stays 0.
  - When the timer reaches 0: set the timer to PULSE_LOW-1 and go to LOW.
- LOW:
  - Both COUNT outputs are 0.
  - When the timer reaches 0, go to IDLE.
- COUNT outputs are registered. COUNT_x is high for exactly PULSE_HIGH cycles and then low for at least PULSE_LOW cycles. Each rising edge on COUNT_x advances the score counter by 1.
- Latency:
  - HIT at edge N is reflected in PENDING at N+1.
  - The earliest COUNT rise is at edge N+2.
  - Per-point period is PULSE_HIGH+PULSE_LOW+1 cycles.
- COUNT_1 and COUNT_2 are never high together. A pulse already started always completes unless START_GAME_N or RESET_N intervenes.
- HIT with HIT_POINTS=0 has no effect, including on BUSY.
- BUSY = (state != IDLE) || PENDING_1 != 0 || PENDING_2 != 0.
- OVERFLOW clears only on reset or START_GAME_N.

Decomposition:
- Shared package score_pkg holds:
  - the state enum score_seq_state_t {IDLE, HIGH, LOW};
  - constants SCORE_PULSE_HIGH_DEF=2 and SCORE_PULSE_LOW_DEF=2;
  - the points width SCORE_PTS_W=3.
- One sub-module, score_pending_acc: a saturating add/decrement accumulator with an overflow output, instanced once per player.
- The FSM, timer and round-robin pointer live in the top module.

Test Plan (PEND_W=5, PULSE_HIGH=2, PULSE_LOW=2):
- Single award: HIT, player 1, points 3 → PENDING_1 = 3 next cycle; then 3 COUNT_1 pulses, each 2 cycles high and 2 low; COUNT_2 stays 0; BUSY drops after the final LOW.
- Arbitration: after reset, award player 1 = 2 and player 2 = 2 in the same cycle window → pulse order COUNT_1, COUNT_2, COUNT_1, COUNT_2; the two outputs are never high together.
- Simultaneous increment and decrement: PENDING_1 = 1, and HIT player 1 points 5 on the IDLE issue cycle → PENDING_1 = 5 next cycle; 5 further pulses follow.
- Saturation (PEND_W=4): PENDING_2 = 14, HIT player 2 points 7 → PENDING_2 = 15 and OVERFLOW = 1; OVERFLOW stays set until START_GAME_N=0.
- Game clear mid-pulse: START_GAME_N=0 during HIGH → next cycle COUNT = 0, both PENDING = 0, BUSY = 0, FSM = IDLE; a HIT in the same cycle is discarded.
- Async reset: RESET_N=0 mid-HIGH between edges → COUNT_1/2, BUSY and OVERFLOW go to 0 without waiting for a CLK_DRV edge; after release the first award is served to player 1.

Source files
------------

// File: rtl/score_pkg.sv
// score_pkg: shared state encoding, default pulse timing and the award-points width
package score_pkg;
    typedef enum logic [1:0] {IDLE, HIGH, LOW} score_seq_state_t;
    localparam int SCORE_PULSE_HIGH_DEF = 2;
    localparam int SCORE_PULSE_LOW_DEF = 2;
    localparam int SCORE_PTS_W = 3;
endpackage

// File: rtl/score_count_sequencer_if.sv
// score_count_sequencer_if: award strobes in, count clocks and status out
interface score_count_sequencer_if #(parameter int PEND_W = 5);
    import score_pkg::*;
    logic HIT;
    logic HIT_PLAYER2;
    logic [SCORE_PTS_W-1:0] HIT_POINTS;
    logic COUNT_1;
    logic COUNT_2;
    logic BUSY;
    logic OVERFLOW;
    logic [PEND_W-1:0] PENDING_1;
    logic [PEND_W-1:0] PENDING_2;
    modport master (
        output HIT, HIT_PLAYER2, HIT_POINTS,
        input COUNT_1, COUNT_2, BUSY, OVERFLOW, PENDING_1, PENDING_2
    );
    modport slave (
        input HIT, HIT_PLAYER2, HIT_POINTS,
        output COUNT_1, COUNT_2, BUSY, OVERFLOW, PENDING_1, PENDING_2
    );
endinterface

// File: rtl/score_pending_acc.sv
// score_pending_acc: saturating pending-points accumulator with sticky overflow
module score_pending_acc
    import score_pkg::*;
#(
    parameter int W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic [SCORE_PTS_W-1:0] inc,
    input  logic                   dec,
    output logic [W-1:0]           pend,
    output logic                   ovf
);
    localparam logic [W:0] MAX = {1'b0, {W{1'b1}}};
    logic [W:0]   sum;
    logic [W-1:0] pend_d, pend_q;
    logic         ovf_d, ovf_q;
    // add award and remove issued point together; one extra bit exposes saturation
    always_comb begin
        sum = {1'b0, pend_q} + (W+1)'(inc) - (W+1)'(dec);
        pend_d = clr ? '0 : (sum > MAX ? MAX[W-1:0] : sum[W-1:0]);
        ovf_d = clr ? 1'b0 : (ovf_q || sum > MAX);
    end
    // accumulator and sticky overflow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end
    assign pend = pend_q;
    assign ovf  = ovf_q;
endmodule

// File: rtl/score_count_sequencer.sv
// score_count_sequencer: converts point awards into round-robin COUNT pulses per player
module score_count_sequencer
    import score_pkg::*;
#(
    parameter int PEND_W     = 5,
    parameter int PULSE_HIGH = SCORE_PULSE_HIGH_DEF,
    parameter int PULSE_LOW  = SCORE_PULSE_LOW_DEF
) (
    input logic                 CLK_DRV,
    input logic                 RESET_N,
    input logic                 START_GAME_N,
    score_count_sequencer_if.slave bus
);
    localparam logic [3:0] T_HIGH = 4'(PULSE_HIGH - 1);
    localparam logic [3:0] T_LOW  = 4'(PULSE_LOW - 1);
    score_seq_state_t       state_d, state_q;
    logic [3:0]             timer_d, timer_q;
    logic                   ptr_d, ptr_q, player_d, player_q;
    logic                   count1_d, count1_q, count2_d, count2_q;
    logic                   issue1, issue2, any1, any2, sel_p2, ovf1, ovf2, clr;
    logic [SCORE_PTS_W-1:0] inc1, inc2;
    logic [PEND_W-1:0]      pend1, pend2;

    assign clr    = !START_GAME_N;
    assign any1   = pend1 != '0;
    assign any2   = pend2 != '0;
    assign sel_p2 = (any1 && any2) ? ptr_q : any2;
    assign inc1   = (bus.HIT && !bus.HIT_PLAYER2) ? bus.HIT_POINTS : '0;
    assign inc2   = (bus.HIT && bus.HIT_PLAYER2) ? bus.HIT_POINTS : '0;

    score_pending_acc #(.W(PEND_W)) u_acc1 (
        .clk(CLK_DRV), .rst_n(RESET_N), .clr(clr),
        .inc(inc1), .dec(issue1), .pend(pend1), .ovf(ovf1)
    );
    score_pending_acc #(.W(PEND_W)) u_acc2 (
        .clk(CLK_DRV), .rst_n(RESET_N), .clr(clr),
        .inc(inc2), .dec(issue2), .pend(pend2), .ovf(ovf2)
    );

    // pulse sequencing: pick a player in IDLE, time the high and low phases
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        ptr_d    = ptr_q;
        player_d = player_q;
        issue1   = 1'b0;
        issue2   = 1'b0;
        if (clr) begin
            state_d  = IDLE;
            timer_d  = '0;
            ptr_d    = 1'b0;
            player_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (any1 || any2) begin
                    issue1   = !sel_p2;
                    issue2   = sel_p2;
                    player_d = sel_p2;
                    ptr_d    = !sel_p2;
                    timer_d  = T_HIGH;
                    state_d  = HIGH;
                end
                HIGH: if (timer_q == 4'd0) begin
                    timer_d = T_LOW;
                    state_d = LOW;
                end else timer_d = timer_q - 4'd1;
                LOW: if (timer_q == 4'd0) state_d = IDLE;
                     else timer_d = timer_q - 4'd1;
                default: state_d = IDLE;
            endcase
        end
        count1_d = state_d == HIGH && !player_d;
        count2_d = state_d == HIGH && player_d;
    end

    // FSM, timer, pointer and registered count outputs
    always_ff @(posedge CLK_DRV or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            ptr_q    <= 1'b0;
            player_q <= 1'b0;
            count1_q <= 1'b0;
            count2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            ptr_q    <= ptr_d;
            player_q <= player_d;
            count1_q <= count1_d;
            count2_q <= count2_d;
        end
    end

    assign bus.COUNT_1   = count1_q;
    assign bus.COUNT_2   = count2_q;
    assign bus.BUSY      = state_q != IDLE || any1 || any2;
    assign bus.OVERFLOW  = ovf1 || ovf2;
    assign bus.PENDING_1 = pend1;
    assign bus.PENDING_2 = pend2;
endmodule

// File: tb/tb_score_count_sequencer.sv
// tb_score_count_sequencer: directed checks of award accumulation, pulse timing and arbitration
module tb_score_count_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start_n = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [31:0] c1, c2, bz;

    score_count_sequencer_if #(.PEND_W(5)) ba();
    score_count_sequencer_if #(.PEND_W(4)) bb();

    score_count_sequencer #(.PEND_W(5), .PULSE_HIGH(2), .PULSE_LOW(2)) dut_a (
        .CLK_DRV(clk), .RESET_N(rst_n), .START_GAME_N(start_n), .bus(ba)
    );
    score_count_sequencer #(.PEND_W(4), .PULSE_HIGH(2), .PULSE_LOW(2)) dut_b (
        .CLK_DRV(clk), .RESET_N(rst_n), .START_GAME_N(start_n), .bus(bb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hit_a(input logic p2, input logic [2:0] pts);
        ba.HIT = 1'b1;
        ba.HIT_PLAYER2 = p2;
        ba.HIT_POINTS = pts;
    endtask

    task automatic run(input int n);
        c1 = '0;
        c2 = '0;
        bz = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            ba.HIT = 1'b0;
            c1 = {c1[30:0], ba.COUNT_1};
            c2 = {c2[30:0], ba.COUNT_2};
            bz = {bz[30:0], ba.BUSY};
        end
    endtask

    initial begin
        ba.HIT = 1'b0; ba.HIT_PLAYER2 = 1'b0; ba.HIT_POINTS = '0;
        bb.HIT = 1'b0; bb.HIT_PLAYER2 = 1'b0; bb.HIT_POINTS = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_count1", ba.COUNT_1, 0);
        check("rst_count2", ba.COUNT_2, 0);
        check("rst_busy", ba.BUSY, 0);
        check("rst_pend1", ba.PENDING_1, 0);
        check("rst_pend2", ba.PENDING_2, 0);
        check("rst_ovf", ba.OVERFLOW, 0);
        #5 rst_n = 1'b1;
        tick();

        hit_a(0, 3); tick(); ba.HIT = 1'b0;
        check("single_pend1", ba.PENDING_1, 3);
        check("single_busy", ba.BUSY, 1);
        check("single_c1_first", ba.COUNT_1, 0);
        run(15);
        check("single_c1_seq", c1, 32'b110001100011000);
        check("single_c2_seq", c2, 0);
        check("single_busy_seq", bz, 32'b111111111111110);

        hit_a(0, 0); tick(); ba.HIT = 1'b0;
        check("zero_busy", ba.BUSY, 0);
        check("zero_pend1", ba.PENDING_1, 0);
        tick();
        check("zero_c1", ba.COUNT_1, 0);

        hit_a(0, 2); tick();
        check("arb_pend1", ba.PENDING_1, 2);
        hit_a(1, 2); run(20);
        check("arb_c1_seq", c1, 32'b11000000001100000000);
        check("arb_c2_seq", c2, 32'b00000110000000011000);
        check("arb_overlap", c1 & c2, 0);
        check("arb_busy_end", ba.BUSY, 0);

        hit_a(0, 1); tick();
        hit_a(0, 5); tick(); ba.HIT = 1'b0;
        check("incdec_pend1", ba.PENDING_1, 5);
        check("incdec_c1", ba.COUNT_1, 1);
        run(25);
        check("incdec_c1_seq", c1, 32'b1000110001100011000110001);
        run(4);
        check("incdec_tail", c1, 32'b1000);
        check("incdec_busy_end", bz[0], 0);
        check("incdec_pend_end", ba.PENDING_1, 0);

        hit_a(1, 3); tick(); ba.HIT = 1'b0; tick();
        check("clr_c2_before", ba.COUNT_2, 1);
        start_n = 1'b0; hit_a(0, 4); tick();
        check("clr_c1", ba.COUNT_1, 0);
        check("clr_c2", ba.COUNT_2, 0);
        check("clr_pend1", ba.PENDING_1, 0);
        check("clr_pend2", ba.PENDING_2, 0);
        check("clr_busy", ba.BUSY, 0);
        start_n = 1'b1; ba.HIT = 1'b0; tick();
        check("clr_idle_busy", ba.BUSY, 0);
        check("clr_idle_c2", ba.COUNT_2, 0);

        bb.HIT = 1'b1; bb.HIT_PLAYER2 = 1'b1; bb.HIT_POINTS = 3'd7; tick();
        check("sat_pend_7", bb.PENDING_2, 7);
        tick();
        check("sat_pend_13", bb.PENDING_2, 13);
        bb.HIT_POINTS = 3'd1; tick();
        check("sat_pend_14", bb.PENDING_2, 14);
        check("sat_ovf_before", bb.OVERFLOW, 0);
        bb.HIT_POINTS = 3'd7; tick(); bb.HIT = 1'b0;
        check("sat_pend_15", bb.PENDING_2, 15);
        check("sat_ovf", bb.OVERFLOW, 1);
        repeat (10) tick();
        check("sat_ovf_sticky", bb.OVERFLOW, 1);
        check("sat_ovf_other", ba.OVERFLOW, 0);
        start_n = 1'b0; tick(); start_n = 1'b1;
        check("sat_ovf_clr", bb.OVERFLOW, 0);
        check("sat_pend_clr", bb.PENDING_2, 0);

        hit_a(0, 2); bb.HIT = 1'b1; bb.HIT_PLAYER2 = 1'b1; bb.HIT_POINTS = 3'd7; tick();
        ba.HIT = 1'b0; tick();
        tick(); bb.HIT = 1'b0;
        check("arst_c1_before", ba.COUNT_1, 1);
        check("arst_ovf_before", bb.OVERFLOW, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_c1", ba.COUNT_1, 0);
        check("arst_busy", ba.BUSY, 0);
        check("arst_pend1", ba.PENDING_1, 0);
        check("arst_ovf", bb.OVERFLOW, 0);
        check("arst_busy_b", bb.BUSY, 0);
        #2 rst_n = 1'b1;
        hit_a(0, 3); tick(); ba.HIT = 1'b0; tick();
        check("arst_after_c1", ba.COUNT_1, 1);
        check("arst_after_c2", ba.COUNT_2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
